// File: rtl/fcs_xor_stream_pkg.sv
// Shared types and constants for the delta-FCS streaming engine.
package fcs_xor_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SHIFT = 2'd2
    } fcs_state_e;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    localparam logic MODE_DELTA = 1'b0;
    localparam logic MODE_ABS   = 1'b1;

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational CRC advance over DATA_W bits, MSB of i_data consumed first.
module crc_lfsr_step #(
    parameter int unsigned      CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = {CRC_W{1'b0}},
    parameter int unsigned      DATA_W = 1
) (
    input  logic [CRC_W-1:0]  i_state,
    input  logic [DATA_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_state
);

    logic [CRC_W-1:0] w_acc;

    always_comb begin
        w_acc = i_state;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ (POLY & {CRC_W{i_data[i] ^ w_acc[CRC_W-1]}});
        end
        o_state = w_acc;
    end

endmodule

// File: rtl/fcs_xor_stream.sv
// Framed CRC engine producing delta or complemented FCS, then serialising it MSB-first.
module fcs_xor_stream
    import fcs_xor_stream_pkg::*;
#(
    parameter int unsigned      CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b1}},
    parameter int unsigned      DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_first,
    input  logic              s_last,
    input  logic              mode,
    input  logic              abort,
    output logic              fcs_valid,
    output logic [CRC_W-1:0]  fcs_val,
    output logic              fcs_bit,
    output logic              fcs_bit_valid,
    output logic              drop
);

    localparam int unsigned      CNT_W    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_W - 1);

    fcs_state_e       r_state;
    fcs_state_e       w_state_nxt;
    logic [CRC_W-1:0] r_data_crc,  w_data_nxt;
    logic [CRC_W-1:0] r_zero_crc,  w_zero_nxt;
    logic [CRC_W-1:0] r_fcs_val,   w_fcs_val_nxt;
    logic [CRC_W-1:0] r_shift,     w_shift_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_mode,      w_mode_nxt;
    logic             r_fcs_valid, w_fcs_valid_nxt;
    logic             r_bit_valid, w_bit_valid_nxt;
    logic             r_fcs_bit,   w_fcs_bit_nxt;
    logic             r_drop,      w_drop_nxt;
    logic             r_s_ready;
    logic             w_load;

    logic             w_xfer;
    logic             w_restart;
    logic             w_mode_eff;
    logic [CRC_W-1:0] w_data_base, w_zero_base;
    logic [CRC_W-1:0] w_data_step, w_zero_step;
    logic [CRC_W-1:0] w_result;

    assign w_xfer      = s_valid && r_s_ready;
    assign w_restart   = (r_state == ST_IDLE) || s_first;
    assign w_data_base = w_restart ? INIT : r_data_crc;
    assign w_zero_base = w_restart ? INIT : r_zero_crc;
    assign w_mode_eff  = s_first ? mode : r_mode;
    assign w_result    = (w_mode_eff == MODE_ABS) ? ~w_data_step : (w_data_step ^ w_zero_step);

    crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY), .DATA_W(DATA_W)) u_step_data (
        .i_state (w_data_base),
        .i_data  (s_data),
        .o_state (w_data_step)
    );

    // Reference run over an all-zero stream of equal length.
    crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY), .DATA_W(DATA_W)) u_step_zero (
        .i_state (w_zero_base),
        .i_data  ({DATA_W{1'b0}}),
        .o_state (w_zero_step)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data_crc;
        w_zero_nxt      = r_zero_crc;
        w_mode_nxt      = r_mode;
        w_fcs_val_nxt   = r_fcs_val;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_fcs_valid_nxt = 1'b0;
        w_bit_valid_nxt = 1'b0;
        w_fcs_bit_nxt   = 1'b0;
        w_drop_nxt      = 1'b0;
        w_load          = 1'b0;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_data_nxt  = INIT;
            w_zero_nxt  = INIT;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (s_first) begin
                            w_data_nxt  = w_data_step;
                            w_zero_nxt  = w_zero_step;
                            w_mode_nxt  = mode;
                            w_state_nxt = ST_ACCUM;
                            w_load      = s_last;
                        end else begin
                            w_drop_nxt = 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_xfer) begin
                        w_data_nxt = w_data_step;
                        w_zero_nxt = w_zero_step;
                        if (s_first) begin
                            w_mode_nxt = mode;
                        end
                        w_load = s_last;
                    end
                end
                ST_SHIFT: begin
                    w_bit_valid_nxt = 1'b1;
                    w_fcs_bit_nxt   = r_shift[CRC_W-1];
                    w_shift_nxt     = {r_shift[CRC_W-2:0], 1'b0};
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        w_state_nxt     = ST_IDLE;
                        w_bit_valid_nxt = 1'b0;
                        w_fcs_bit_nxt   = 1'b0;
                        w_cnt_nxt       = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // Final beat: publish the result and present its MSB in the same cycle.
            if (w_load) begin
                w_state_nxt     = ST_SHIFT;
                w_fcs_val_nxt   = w_result;
                w_fcs_valid_nxt = 1'b1;
                w_bit_valid_nxt = 1'b1;
                w_fcs_bit_nxt   = w_result[CRC_W-1];
                w_shift_nxt     = {w_result[CRC_W-2:0], 1'b0};
                w_cnt_nxt       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_data_crc  <= INIT;
            r_zero_crc  <= INIT;
            r_mode      <= MODE_DELTA;
            r_fcs_val   <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_fcs_valid <= 1'b0;
            r_bit_valid <= 1'b0;
            r_fcs_bit   <= 1'b0;
            r_drop      <= 1'b0;
            r_s_ready   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_data_crc  <= w_data_nxt;
            r_zero_crc  <= w_zero_nxt;
            r_mode      <= w_mode_nxt;
            r_fcs_val   <= w_fcs_val_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fcs_valid <= w_fcs_valid_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_fcs_bit   <= w_fcs_bit_nxt;
            r_drop      <= w_drop_nxt;
            r_s_ready   <= (w_state_nxt != ST_SHIFT);
        end
    end

    assign s_ready       = r_s_ready;
    assign fcs_valid     = r_fcs_valid;
    assign fcs_val       = r_fcs_val;
    assign fcs_bit       = r_fcs_bit;
    assign fcs_bit_valid = r_bit_valid;
    assign drop          = r_drop;

endmodule

// File: tb/tb_fcs_xor_stream.sv
// Bench for fcs_xor_stream: three instances (1, 4 and 8 bits per beat) against a polynomial-division model.
module tb_fcs_xor_stream;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] INIT = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        sv  [3];
    logic        sf  [3];
    logic        sl  [3];
    logic        md  [3];
    logic        ab  [3];
    logic [7:0]  sd  [3];
    logic        sr  [3];
    logic        fv  [3];
    logic        fb  [3];
    logic        fbv [3];
    logic        dr  [3];
    logic [31:0] fval[3];

    int checks;
    int failures;
    logic [7:0] beat_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fcs_xor_stream #(.DATA_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0][0:0]),
        .s_first(sf[0]), .s_last(sl[0]), .mode(md[0]), .abort(ab[0]), .fcs_valid(fv[0]),
        .fcs_val(fval[0]), .fcs_bit(fb[0]), .fcs_bit_valid(fbv[0]), .drop(dr[0])
    );

    fcs_xor_stream #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1][3:0]),
        .s_first(sf[1]), .s_last(sl[1]), .mode(md[1]), .abort(ab[1]), .fcs_valid(fv[1]),
        .fcs_val(fval[1]), .fcs_bit(fb[1]), .fcs_bit_valid(fbv[1]), .drop(dr[1])
    );

    fcs_xor_stream #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
        .s_first(sf[2]), .s_last(sl[2]), .mode(md[2]), .abort(ab[2]), .fcs_valid(fv[2]),
        .fcs_val(fval[2]), .fcs_bit(fb[2]), .fcs_bit_valid(fbv[2]), .drop(dr[2])
    );

    function automatic int dw_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
    endfunction

    // CRC of beat_q[from..] as polynomial division with a given preset.
    function automatic logic [31:0] crc_ref(input logic [31:0] preset, input int d, input int from);
        logic [31:0] c;
        logic        top;
        c = preset;
        for (int i = from; i < beat_q.size(); i++) begin
            for (int b = dw_of(d) - 1; b >= 0; b--) begin
                top = c[31] ^ beat_q[i][b];
                c   = {c[30:0], 1'b0};
                if (top) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Delta result is the linear part alone, i.e. a CRC with zero preset.
    function automatic logic [31:0] expect_fcs(input logic m, input int d, input int from);
        return m ? ~crc_ref(INIT, d, from) : crc_ref(32'h0, d, from);
    endfunction

    task automatic run_frame(input int d, input logic m, input int restart_at,
                             output logic [31:0] got, output logic [31:0] ser,
                             output logic fv0, output int nfv, output int nbv, output int nrdy);
        int n;
        n = beat_q.size();
        for (int i = 0; i < n; i++) begin
            sv[d] = 1'b1;
            sd[d] = beat_q[i];
            sf[d] = (i == 0) || (restart_at > 0 && i == restart_at);
            sl[d] = (i == n - 1);
            md[d] = sf[d] ? m : ~m;
            @(posedge clk); #1;
        end
        sv[d] = 1'b0; sf[d] = 1'b0; sl[d] = 1'b0;
        got = fval[d];
        fv0 = fv[d];
        nfv = 0; nbv = 0; nrdy = 0; ser = '0;
        for (int k = 0; k < 32; k++) begin
            if (fv[d])  nfv++;
            if (fbv[d]) nbv++;
            if (sr[d])  nrdy++;
            ser[31-k] = fb[d];
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sv[d] = 0; sf[d] = 0; sl[d] = 0; md[d] = 0; ab[d] = 0; sd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sr[d] !== 1'b1 || fv[d] !== 1'b0 || fbv[d] !== 1'b0 || fb[d] !== 1'b0 ||
                dr[d] !== 1'b0 || fval[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_values dut%0d got rdy=%b fv=%b bv=%b b=%b drop=%b val=%h exp 1,0,0,0,0,0",
                         d, sr[d], fv[d], fbv[d], fb[d], dr[d], fval[d]);
            end
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_bit();
        logic [31:0] got, ser, exp;
        logic fv0;
        int nfv, nbv, nrdy;
        for (int m = 0; m < 2; m++) begin
            beat_q = {8'h01};
            exp = (m == 0) ? 32'h04C1_1DB7 : 32'h0000_0001;
            run_frame(0, m[0], 0, got, ser, fv0, nfv, nbv, nrdy);
            checks++;
            if (got !== exp) begin failures++; $display("FAIL single_bit_val mode=%0d got=%h exp=%h", m, got, exp); end
            checks++;
            if (got !== expect_fcs(m[0], 0, 0)) begin failures++; $display("FAIL single_bit_model mode=%0d got=%h exp=%h", m, got, expect_fcs(m[0], 0, 0)); end
            checks++;
            if (ser !== exp) begin failures++; $display("FAIL single_bit_serial mode=%0d got=%h exp=%h", m, ser, exp); end
            checks++;
            if (fv0 !== 1'b1 || nfv != 1) begin failures++; $display("FAIL single_bit_strobe mode=%0d first=%b count=%0d exp 1,1", m, fv0, nfv); end
            checks++;
            if (nbv != 32 || nrdy != 0) begin failures++; $display("FAIL single_bit_shift mode=%0d bits=%0d ready_hi=%0d exp 32,0", m, nbv, nrdy); end
            checks++;
            if (fbv[0] !== 1'b0 || sr[0] !== 1'b1) begin failures++; $display("FAIL single_bit_end mode=%0d bv=%b rdy=%b exp 0,1", m, fbv[0], sr[0]); end
        end
    endtask

    task automatic test_ascii();
        logic [31:0] got, ser;
        logic fv0;
        int nfv, nbv, nrdy;
        beat_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(2, 1'b1, 0, got, ser, fv0, nfv, nbv, nrdy);
        checks++;
        if (got !== 32'hFC89_1918) begin failures++; $display("FAIL ascii_abs got=%h exp=fc891918", got); end
        checks++;
        if (ser !== 32'hFC89_1918 || nbv != 32) begin failures++; $display("FAIL ascii_serial got=%h bits=%0d exp=fc891918,32", ser, nbv); end
        beat_q = {};
        for (int i = 0; i < 9; i++) beat_q.push_back(8'h00);
        run_frame(2, 1'b0, 0, got, ser, fv0, nfv, nbv, nrdy);
        checks++;
        if (got !== 32'h0 || fv0 !== 1'b1) begin failures++; $display("FAIL zero_delta got=%h strobe=%b exp=0,1", got, fv0); end
    endtask

    task automatic test_linearity();
        logic [7:0]  qa[$], qb[$];
        logic [31:0] da, db, dx, ser;
        logic fv0;
        int nfv, nbv, nrdy, len;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(2, 10);
            qa = {}; qb = {};
            for (int i = 0; i < len; i++) begin
                qa.push_back(8'($urandom_range(0, 15)));
                qb.push_back(8'($urandom_range(0, 15)));
            end
            beat_q = qa;
            run_frame(1, 1'b0, 0, da, ser, fv0, nfv, nbv, nrdy);
            checks++;
            if (da !== expect_fcs(1'b0, 1, 0) || ser !== da || nrdy != 0) begin
                failures++;
                $display("FAIL lin_a it=%0d got=%h ser=%h rdy_hi=%0d exp=%h", it, da, ser, nrdy, expect_fcs(1'b0, 1, 0));
            end
            beat_q = qb;
            run_frame(1, 1'b0, 0, db, ser, fv0, nfv, nbv, nrdy);
            beat_q = {};
            for (int i = 0; i < len; i++) beat_q.push_back(qa[i] ^ qb[i]);
            run_frame(1, 1'b0, 0, dx, ser, fv0, nfv, nbv, nrdy);
            checks++;
            if ((da ^ db) !== dx || nrdy != 0) begin
                failures++;
                $display("FAIL lin_xor it=%0d got=%h exp=%h rdy_hi=%0d", it, dx, da ^ db, nrdy);
            end
        end
        for (int it = 0; it < 2; it++) begin
            beat_q = {};
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) beat_q.push_back(8'($urandom_range(0, 255)));
            run_frame(2, 1'b1, 0, da, ser, fv0, nfv, nbv, nrdy);
            checks++;
            if (da !== expect_fcs(1'b1, 2, 0)) begin failures++; $display("FAIL rand_abs8 it=%0d got=%h exp=%h", it, da, expect_fcs(1'b1, 2, 0)); end
        end
    endtask

    task automatic test_drop_restart();
        logic [31:0] got, ser;
        logic fv0;
        int nfv, nbv, nrdy;
        sv[0] = 1'b1; sf[0] = 1'b0; sl[0] = 1'b1; sd[0] = 8'h01;
        @(posedge clk); #1;
        sv[0] = 1'b0; sl[0] = 1'b0;
        checks++;
        if (dr[0] !== 1'b1 || fv[0] !== 1'b0) begin failures++; $display("FAIL drop_pulse got drop=%b fv=%b exp 1,0", dr[0], fv[0]); end
        nfv = 0; nrdy = 0;
        for (int k = 0; k < 4; k++) begin
            if (dr[0]) nrdy++;
            @(posedge clk); #1;
            if (fv[0]) nfv++;
        end
        checks++;
        if (nfv != 0 || nrdy != 1) begin failures++; $display("FAIL drop_once got fv_count=%0d drop_count=%0d exp 0,1", nfv, nrdy); end
        beat_q = {};
        for (int i = 0; i < 7; i++) beat_q.push_back(8'($urandom_range(0, 255)));
        run_frame(2, 1'b0, 3, got, ser, fv0, nfv, nbv, nrdy);
        checks++;
        if (got !== expect_fcs(1'b0, 2, 3) || nfv != 1) begin
            failures++;
            $display("FAIL restart got=%h strobes=%0d exp=%h,1", got, nfv, expect_fcs(1'b0, 2, 3));
        end
    endtask

    task automatic test_abort();
        logic [31:0] got, ser;
        logic fv0;
        int nfv, nbv, nrdy;
        sv[0] = 1'b1; sf[0] = 1'b1; sl[0] = 1'b1; sd[0] = 8'h01; md[0] = 1'b0;
        @(posedge clk); #1;
        sv[0] = 1'b0; sf[0] = 1'b0; sl[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ab[0] = 1'b1;
        @(posedge clk); #1;
        ab[0] = 1'b0;
        checks++;
        if (fbv[0] !== 1'b0 || sr[0] !== 1'b1 || fval[0] !== 32'h04C1_1DB7) begin
            failures++;
            $display("FAIL abort_shift got bv=%b rdy=%b val=%h exp 0,1,04c11db7", fbv[0], sr[0], fval[0]);
        end
        // Abort in ACCUM with a concurrent last beat: nothing must emerge.
        sv[2] = 1'b1; sf[2] = 1'b1; sl[2] = 1'b0; sd[2] = 8'hA5; md[2] = 1'b0;
        @(posedge clk); #1;
        sf[2] = 1'b0; sl[2] = 1'b1; ab[2] = 1'b1;
        @(posedge clk); #1;
        sv[2] = 1'b0; sl[2] = 1'b0; ab[2] = 1'b0;
        nfv = 0;
        for (int k = 0; k < 4; k++) begin
            if (fv[2] || dr[2]) nfv++;
            @(posedge clk); #1;
        end
        checks++;
        if (nfv != 0 || sr[2] !== 1'b1) begin failures++; $display("FAIL abort_accum got events=%0d rdy=%b exp 0,1", nfv, sr[2]); end
        beat_q = {8'h00};
        run_frame(0, 1'b1, 0, got, ser, fv0, nfv, nbv, nrdy);
        checks++;
        if (got !== expect_fcs(1'b1, 0, 0) || ser !== got) begin
            failures++;
            $display("FAIL after_abort got=%h ser=%h exp=%h", got, ser, expect_fcs(1'b1, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, ser;
        logic fv0;
        int nfv, nbv, nrdy;
        sv[2] = 1'b1; sf[2] = 1'b1; sl[2] = 1'b0; sd[2] = 8'h5A; md[2] = 1'b1;
        @(posedge clk); #1;
        sf[2] = 1'b0; sd[2] = 8'h3C;
        @(posedge clk); #1;
        sv[2] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fval[2] !== 32'h0 || sr[2] !== 1'b1 || fv[2] !== 1'b0 || fbv[2] !== 1'b0 || dr[2] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got val=%h rdy=%b fv=%b bv=%b drop=%b exp 0,1,0,0,0", fval[2], sr[2], fv[2], fbv[2], dr[2]);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        beat_q = {};
        for (int i = 0; i < 4; i++) beat_q.push_back(8'($urandom_range(0, 255)));
        run_frame(2, 1'b0, 0, got, ser, fv0, nfv, nbv, nrdy);
        checks++;
        if (got !== expect_fcs(1'b0, 2, 0) || ser !== got) begin
            failures++;
            $display("FAIL after_reset got=%h ser=%h exp=%h", got, ser, expect_fcs(1'b0, 2, 0));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_bit();
        test_ascii();
        test_linearity();
        test_drop_restart();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
